// File: rtl/m_icache_ctrl.sv
// m_icache_ctrl: instruction cache refill controller.
// Hits return in the same cycle; misses issue one memory read with timed retry, then fill and deliver.
module m_icache_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic [31:0] w_pc,
    input  logic        w_req,
    input  logic        w_flush,
    output logic [31:0] w_insn,
    output logic        w_vld,
    output logic        w_stall,
    output logic [31:0] w_c_adr,
    input  logic        w_c_hit,
    input  logic [31:0] w_c_dout,
    output logic [4:0]  w_c_wadr,
    output logic        w_c_we,
    output logic [57:0] w_c_wd,
    output logic        w_m_re,
    output logic [31:0] w_m_adr,
    input  logic [31:0] w_m_insn,
    input  logic        w_m_oe,
    output logic [15:0] r_hits,
    output logic [15:0] r_misses
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} t_state;

    t_state      r_state, w_nxt;
    logic [31:0] r_mpc, r_data;
    logic [7:0]  r_wcnt;
    logic        r_kill;
    logic        w_idle, w_fill, w_hit, w_miss, w_oe, w_tmo;

    always_comb begin
        w_idle   = r_state == IDLE;
        w_fill   = r_state == FILL;
        w_hit    = w_req & w_c_hit & ~w_flush;
        w_miss   = w_req & ~w_c_hit & ~w_flush;
        w_oe     = w_m_oe & (r_state == REQ || r_state == WAIT);
        w_tmo    = (r_state == WAIT) && (r_wcnt == 8'(MAX_WAIT - 1));
        w_nxt    = IDLE;
        case (r_state)
            IDLE:    w_nxt = w_miss ? REQ : IDLE;
            REQ:     w_nxt = w_oe ? FILL : WAIT;
            WAIT:    w_nxt = w_oe ? FILL : (w_tmo ? REQ : WAIT);
            default: w_nxt = IDLE;
        endcase
        // Gating with w_rst_n keeps the combinational hit/miss paths quiet while reset is held
        w_vld    = w_rst_n & (w_idle ? w_hit : w_fill & ~r_kill & ~w_flush);
        w_insn   = w_vld ? (w_idle ? w_c_dout : r_data) : 32'd0;
        w_stall  = w_rst_n & (w_idle ? w_miss : 1'b1);
        w_c_adr  = w_idle ? w_pc : r_mpc;
        w_c_we   = w_fill;
        w_c_wadr = r_mpc[6:2];
        w_c_wd   = {1'b1, r_mpc[31:7], r_data};
        w_m_re   = r_state == REQ;
        w_m_adr  = r_mpc;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= IDLE;
            r_mpc    <= 32'd0;
            r_data   <= 32'd0;
            r_wcnt   <= 8'd0;
            r_kill   <= 1'b0;
            r_hits   <= 16'd0;
            r_misses <= 16'd0;
        end else begin
            r_state <= w_nxt;
            if (w_idle && w_miss) begin
                r_mpc    <= w_pc;
                r_misses <= r_misses + 16'd1;
            end
            if (w_idle && w_hit)
                r_hits <= r_hits + 16'd1;
            if (r_state == REQ)
                r_wcnt <= 8'd0;
            else if (r_state == WAIT)
                r_wcnt <= r_wcnt + 8'd1;
            if (w_oe)
                r_data <= w_m_insn;
            if (w_fill)
                r_kill <= 1'b0;
            else if (!w_idle && w_flush)
                r_kill <= 1'b1;
        end
    end
endmodule

// File: tb/tb_m_icache_ctrl.sv
// tb_m_icache_ctrl: directed bench with a direct-mapped cache model and a fixed-latency memory model.
module tb_m_icache_ctrl;
    logic        w_clk = 1'b0;
    logic        w_rst_n;
    logic [31:0] w_pc;
    logic        w_req, w_flush;
    logic [31:0] w_insn;
    logic        w_vld, w_stall;
    logic [31:0] w_c_adr;
    logic        w_c_hit;
    logic [31:0] w_c_dout;
    logic [4:0]  w_c_wadr;
    logic        w_c_we;
    logic [57:0] w_c_wd;
    logic        w_m_re;
    logic [31:0] w_m_adr, w_m_insn;
    logic        w_m_oe;
    logic [15:0] r_hits, r_misses;

    int n_chk = 0;
    int n_pass = 0;

    always #5 w_clk = ~w_clk;

    m_icache_ctrl #(.MAX_WAIT(4)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_pc(w_pc), .w_req(w_req), .w_flush(w_flush),
        .w_insn(w_insn), .w_vld(w_vld), .w_stall(w_stall), .w_c_adr(w_c_adr),
        .w_c_hit(w_c_hit), .w_c_dout(w_c_dout), .w_c_wadr(w_c_wadr), .w_c_we(w_c_we),
        .w_c_wd(w_c_wd), .w_m_re(w_m_re), .w_m_adr(w_m_adr), .w_m_insn(w_m_insn),
        .w_m_oe(w_m_oe), .r_hits(r_hits), .r_misses(r_misses)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h40 ? 32'h00A00093 : a ^ 32'h13579BDF;
    endfunction

    // cache model: 32 direct-mapped entries, with a bench-side preload port
    logic        c_v    [32] = '{default: 1'b0};
    logic [24:0] c_tag  [32] = '{default: 25'd0};
    logic [31:0] c_data [32] = '{default: 32'd0};
    logic        pl_en;
    logic [4:0]  pl_idx;
    logic [57:0] pl_wd;

    always @(posedge w_clk) begin
        if (w_c_we) begin
            c_v[w_c_wadr]    <= w_c_wd[57];
            c_tag[w_c_wadr]  <= w_c_wd[56:32];
            c_data[w_c_wadr] <= w_c_wd[31:0];
        end else if (pl_en) begin
            c_v[pl_idx]    <= pl_wd[57];
            c_tag[pl_idx]  <= pl_wd[56:32];
            c_data[pl_idx] <= pl_wd[31:0];
        end
    end
    assign w_c_hit  = c_v[w_c_adr[6:2]] && (c_tag[w_c_adr[6:2]] == w_c_adr[31:7]);
    assign w_c_dout = c_data[w_c_adr[6:2]];

    // memory model: 3-cycle latency, ignores reads while busy, optional dropped response
    logic        m_busy, m_drop;
    logic [1:0]  m_cnt;
    logic [31:0] m_adr;

    always @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 2'd0;
            m_adr  <= 32'd0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 2'd1;
            if (m_cnt == 2'd1) m_busy <= 1'b0;
        end else if (w_m_re) begin
            m_busy <= 1'b1;
            m_cnt  <= 2'd3;
            m_adr  <= w_m_adr;
        end
    end
    assign w_m_oe   = m_busy && m_cnt == 2'd1 && !m_drop;
    assign w_m_insn = w_m_oe ? mem_word(m_adr) : 32'hFFFF_FFFF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        w_rst_n = 1'b0; w_pc = 32'd0; w_req = 1'b0; w_flush = 1'b0;
        pl_en = 1'b0; pl_idx = 5'd0; pl_wd = 58'd0; m_drop = 1'b0;
        repeat (2) @(negedge w_clk);
        #1;
        chk("rst_stall", w_stall, 0); chk("rst_vld", w_vld, 0); chk("rst_re", w_m_re, 0);
        chk("rst_we", w_c_we, 0); chk("rst_hits", r_hits, 0); chk("rst_misses", r_misses, 0);
        @(negedge w_clk); w_rst_n = 1'b1;

        // cold miss at 0x40, then hit
        @(negedge w_clk); w_req = 1'b1; w_pc = 32'h40; #1;
        chk("t1_miss_stall", w_stall, 1); chk("t1_miss_vld", w_vld, 0); chk("t1_cadr", w_c_adr, 32'h40);
        @(negedge w_clk); #1;
        chk("t1_re", w_m_re, 1); chk("t1_madr", w_m_adr, 32'h40); chk("t1_req_we", w_c_we, 0);
        repeat (3) begin
            @(negedge w_clk); #1;
            chk("t1_wait_stall", w_stall, 1); chk("t1_wait_re", w_m_re, 0);
        end
        @(negedge w_clk); #1;
        chk("t1_fill_we", w_c_we, 1); chk("t1_fill_wadr", w_c_wadr, 16);
        chk("t1_fill_wd", w_c_wd, {1'b1, 25'd0, 32'h00A00093});
        chk("t1_fill_vld", w_vld, 1); chk("t1_fill_insn", w_insn, 32'h00A00093);
        chk("t1_fill_re", w_m_re, 0); chk("t1_fill_stall", w_stall, 1);
        @(negedge w_clk); #1;
        chk("t1_hit_vld", w_vld, 1); chk("t1_hit_insn", w_insn, 32'h00A00093); chk("t1_hit_stall", w_stall, 0);
        @(negedge w_clk); w_req = 1'b0; #1;
        chk("t1_hits", r_hits, 1); chk("t1_misses", r_misses, 1); chk("t1_idle_insn", w_insn, 0);

        // back-to-back hits
        @(negedge w_clk); pl_en = 1'b1; pl_idx = 5'd17; pl_wd = {1'b1, 25'd0, 32'h00100113};
        @(negedge w_clk); pl_en = 1'b0; w_req = 1'b1; w_pc = 32'h40; #1;
        chk("t2_vld0", w_vld, 1); chk("t2_insn0", w_insn, 32'h00A00093); chk("t2_stall0", w_stall, 0);
        @(negedge w_clk); w_pc = 32'h44; #1;
        chk("t2_vld1", w_vld, 1); chk("t2_insn1", w_insn, 32'h00100113); chk("t2_stall1", w_stall, 0);
        @(negedge w_clk); w_req = 1'b0; #1;
        chk("t2_hits", r_hits, 3);

        // flush during WAIT
        @(negedge w_clk); w_req = 1'b1; w_pc = 32'h80; #1;
        chk("t3_miss_stall", w_stall, 1);
        @(negedge w_clk); #1;
        chk("t3_re", w_m_re, 1);
        @(negedge w_clk); w_flush = 1'b1; #1;
        chk("t3_flush_vld", w_vld, 0); chk("t3_flush_stall", w_stall, 1);
        @(negedge w_clk); w_flush = 1'b0;
        @(negedge w_clk);
        @(negedge w_clk); #1;
        chk("t3_fill_we", w_c_we, 1); chk("t3_fill_wadr", w_c_wadr, 0);
        chk("t3_fill_wd", w_c_wd, {1'b1, 25'd1, mem_word(32'h80)});
        chk("t3_fill_vld", w_vld, 0); chk("t3_fill_insn", w_insn, 0);
        @(negedge w_clk); #1;
        chk("t3_hit_vld", w_vld, 1); chk("t3_hit_insn", w_insn, mem_word(32'h80));
        @(negedge w_clk); w_flush = 1'b1; w_pc = 32'h44; #1;
        chk("t3_idle_flush_vld", w_vld, 0); chk("t3_idle_flush_stall", w_stall, 0);
        @(negedge w_clk); w_pc = 32'h200; #1;
        chk("t3_flush_miss_stall", w_stall, 0);
        @(negedge w_clk); w_flush = 1'b0; w_req = 1'b0; #1;
        chk("t3_misses", r_misses, 2); chk("t3_hits", r_hits, 4);

        // timeout retry with the first response dropped
        m_drop = 1'b1;
        @(negedge w_clk); w_req = 1'b1; w_pc = 32'hC0; #1;
        chk("t4_miss_stall", w_stall, 1);
        @(negedge w_clk); #1;
        chk("t4_re1", w_m_re, 1); chk("t4_madr1", w_m_adr, 32'hC0);
        repeat (4) begin
            @(negedge w_clk); #1;
            chk("t4_wait_re", w_m_re, 0); chk("t4_wait_stall", w_stall, 1);
        end
        m_drop = 1'b0;
        @(negedge w_clk); #1;
        chk("t4_re2", w_m_re, 1); chk("t4_madr2", w_m_adr, 32'hC0);
        repeat (3) begin
            @(negedge w_clk); #1;
            chk("t4_wait2_re", w_m_re, 0); chk("t4_wait2_we", w_c_we, 0);
        end
        @(negedge w_clk); #1;
        chk("t4_fill_we", w_c_we, 1); chk("t4_fill_wadr", w_c_wadr, 16);
        chk("t4_fill_wd", w_c_wd, {1'b1, 25'd1, mem_word(32'hC0)});
        chk("t4_fill_vld", w_vld, 1); chk("t4_fill_insn", w_insn, mem_word(32'hC0));
        @(negedge w_clk); w_req = 1'b0; #1;
        chk("t4_misses", r_misses, 3); chk("t4_hits", r_hits, 4);

        // async reset while in WAIT
        @(negedge w_clk); w_req = 1'b1; w_pc = 32'h100;
        @(negedge w_clk);
        @(negedge w_clk); #1;
        chk("t6_wait_stall", w_stall, 1);
        #2; w_rst_n = 1'b0; w_pc = 32'h44; #1;
        chk("t6_rst_stall", w_stall, 0); chk("t6_rst_vld", w_vld, 0); chk("t6_rst_insn", w_insn, 0);
        chk("t6_rst_re", w_m_re, 0); chk("t6_rst_we", w_c_we, 0);
        chk("t6_rst_hits", r_hits, 0); chk("t6_rst_misses", r_misses, 0);
        repeat (2) begin
            @(negedge w_clk); #1;
            chk("t6_hold_we", w_c_we, 0); chk("t6_hold_vld", w_vld, 0);
        end
        @(negedge w_clk); w_rst_n = 1'b1; w_req = 1'b0;
        repeat (4) begin
            @(negedge w_clk); #1;
            chk("t6_post_we", w_c_we, 0); chk("t6_post_stall", w_stall, 0);
        end
        @(negedge w_clk); w_req = 1'b1; w_pc = 32'h44; #1;
        chk("t6_hit_vld", w_vld, 1); chk("t6_hit_insn", w_insn, 32'h00100113);

        // hit counter wrap: 65536 hits in total from zero
        repeat (65535) @(negedge w_clk);
        #1;
        chk("t5_hits_max", r_hits, 16'hFFFF);
        @(negedge w_clk); w_req = 1'b0; #1;
        chk("t5_hits_wrap", r_hits, 16'h0000); chk("t5_misses", r_misses, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
